// File: rtl/adc_dual_capture_pkg.sv
// Shared types and constants for the dual-channel ADC capture block.
package adc_dual_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2
    } cap_state_t;

    localparam int unsigned SEXT_W  = 16;
    localparam int unsigned CH1_LSB = 0;
    localparam int unsigned CH2_LSB = 16;
    localparam int unsigned TDATA_W = 32;
    localparam int unsigned FIFO_W  = TDATA_W + 1;

endpackage

// File: rtl/adc_dual_capture_fifo.sv
// Synchronous first-word-fall-through FIFO; DEPTH must be a power of two >= 2.
module adc_dual_capture_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/adc_dual_capture.sv
// Dual-channel ADC capture to AXI-Stream with counted bursts and overflow tracking.
// Optional over-range detection: define ADC_DUAL_CAPTURE_OVR_DET_EN.
module adc_dual_capture
    import adc_dual_capture_pkg::*;
#(
    parameter int unsigned INT_ADC_DATA_WIDTH      = 14,
    parameter int unsigned INT_INVERT_IDATA        = 0,
    parameter int unsigned INT_IDATA_ENC_OFFSETBIN = 1,
    parameter int unsigned INT_FIFO_DEPTH          = 4,
    parameter int unsigned INT_CNT_WIDTH           = 16
) (
    input  logic                          in_clk_adc,
    input  logic                          in_rst_n,
    input  logic [INT_ADC_DATA_WIDTH-1:0] in_adc_data_ch1,
    input  logic [INT_ADC_DATA_WIDTH-1:0] in_adc_data_ch2,
    input  logic                          in_start,
    input  logic                          in_abort,
    input  logic [INT_CNT_WIDTH-1:0]      in_sample_count,
    output logic [TDATA_W-1:0]            out_m_axis_tdata,
    output logic                          out_m_axis_tvalid,
    output logic                          out_m_axis_tlast,
    input  logic                          in_m_axis_tready,
    output logic                          out_busy,
    output logic                          out_done,
    output logic                          out_overflow
`ifdef ADC_DUAL_CAPTURE_OVR_DET_EN
   ,output logic                          out_ovr_ch1,
    output logic                          out_ovr_ch2,
    output logic [INT_CNT_WIDTH-1:0]      out_ovr_cnt
`endif
);

    localparam int unsigned W = INT_ADC_DATA_WIDTH;

    function automatic logic [W-1:0] conv_sample(input logic [W-1:0] raw);
        logic [W-1:0] c;
        c = raw;
        if (INT_IDATA_ENC_OFFSETBIN != 0) begin
            if (INT_INVERT_IDATA != 0) c[W-2:0] = ~raw[W-2:0];
            else                       c[W-1]   = ~raw[W-1];
        end else if (INT_INVERT_IDATA != 0) begin
            c = ~raw;
        end
        return c;
    endfunction

    function automatic logic [SEXT_W-1:0] sext(input logic signed [W-1:0] v);
        return SEXT_W'(v);
    endfunction

    cap_state_t                 state;
    logic [INT_CNT_WIDTH-1:0]   remaining;
    logic [W-1:0]               s1_ch1;
    logic [W-1:0]               s1_ch2;
    logic                       s1_vld;
    logic                       s1_last;
    logic [W-1:0]               c1;
    logic [W-1:0]               c2;
    logic [TDATA_W-1:0]         s2_word;
    logic                       s2_vld;
    logic                       s2_last;
    logic                       lw_vld;
    logic [TDATA_W-1:0]         lw_word;
    logic                       abort_act;
    logic                       fifo_wr;
    logic [FIFO_W-1:0]          fifo_din;
    logic [FIFO_W-1:0]          fifo_dout;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       lw_park;
    logic                       wr_drop;

    assign c1        = conv_sample(s1_ch1);
    assign c2        = conv_sample(s1_ch2);
    assign abort_act = in_abort && (state != ST_IDLE);

    // The parked last word has priority; it can only exist once all capture writes are done.
    always_comb begin
        fifo_wr  = 1'b0;
        fifo_din = {s2_last, s2_word};
        lw_park  = 1'b0;
        wr_drop  = 1'b0;
        if (!abort_act) begin
            if (lw_vld) begin
                fifo_din = {1'b1, lw_word};
                fifo_wr  = !fifo_full;
            end else if (s2_vld) begin
                if (!fifo_full)   fifo_wr = 1'b1;
                else if (s2_last) lw_park = 1'b1;
                else              wr_drop = 1'b1;
            end
        end
    end

    adc_dual_capture_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (INT_FIFO_DEPTH)
    ) u_fifo (
        .clk     (in_clk_adc),
        .rst_n   (in_rst_n),
        .flush   (abort_act),
        .wr_en   (fifo_wr),
        .wr_data (fifo_din),
        .rd_en   (in_m_axis_tready),
        .rd_data (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign out_m_axis_tdata  = fifo_dout[TDATA_W-1:0];
    assign out_m_axis_tlast  = fifo_dout[TDATA_W];
    assign out_m_axis_tvalid = !fifo_empty;

    always_ff @(posedge in_clk_adc) begin
        if (!in_rst_n) begin
            state        <= ST_IDLE;
            remaining    <= '0;
            s1_ch1       <= '0;
            s1_ch2       <= '0;
            s1_vld       <= 1'b0;
            s1_last      <= 1'b0;
            s2_word      <= '0;
            s2_vld       <= 1'b0;
            s2_last      <= 1'b0;
            lw_vld       <= 1'b0;
            lw_word      <= '0;
            out_busy     <= 1'b0;
            out_done     <= 1'b0;
            out_overflow <= 1'b0;
        end else begin
            s1_ch1                       <= in_adc_data_ch1;
            s1_ch2                       <= in_adc_data_ch2;
            s2_word[CH1_LSB +: SEXT_W]   <= sext(c1);
            s2_word[CH2_LSB +: SEXT_W]   <= sext(c2);
            s1_vld                       <= 1'b0;
            s1_last                      <= 1'b0;
            s2_vld                       <= s1_vld && !abort_act;
            s2_last                      <= s1_last;
            out_done                     <= 1'b0;

            if (abort_act)               lw_vld <= 1'b0;
            else if (lw_park) begin
                lw_vld  <= 1'b1;
                lw_word <= s2_word;
            end else if (lw_vld && !fifo_full) lw_vld <= 1'b0;

            if (wr_drop) out_overflow <= 1'b1;

            // The counter tags samples at the input; the state leaves CAPTURE when the tag reaches the FIFO.
            case (state)
                ST_IDLE: begin
                    if (in_start && !in_abort) begin
                        if (in_sample_count != '0) begin
                            state        <= ST_CAPTURE;
                            remaining    <= in_sample_count;
                            out_overflow <= 1'b0;
                            out_busy     <= 1'b1;
                        end else begin
                            out_done <= 1'b1;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (abort_act) begin
                        state     <= ST_IDLE;
                        remaining <= '0;
                        out_busy  <= 1'b0;
                    end else begin
                        if (remaining != '0) begin
                            s1_vld    <= 1'b1;
                            s1_last   <= (remaining == INT_CNT_WIDTH'(1));
                            remaining <= remaining - INT_CNT_WIDTH'(1);
                        end
                        if (s2_vld && s2_last) state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (abort_act) begin
                        state    <= ST_IDLE;
                        out_busy <= 1'b0;
                    end else if (fifo_empty && !lw_vld) begin
                        state    <= ST_IDLE;
                        out_busy <= 1'b0;
                        out_done <= 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    out_busy <= 1'b0;
                end
            endcase
        end
    end

`ifdef ADC_DUAL_CAPTURE_OVR_DET_EN
    localparam logic [W-1:0] POS_FS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] NEG_FS = {1'b1, {(W-1){1'b0}}};

    // Flags load on the same edge as s2_word, so they describe the pair in stage 2.
    always_ff @(posedge in_clk_adc) begin
        if (!in_rst_n) begin
            out_ovr_ch1 <= 1'b0;
            out_ovr_ch2 <= 1'b0;
            out_ovr_cnt <= '0;
        end else begin
            out_ovr_ch1 <= (c1 == POS_FS) || (c1 == NEG_FS);
            out_ovr_ch2 <= (c2 == POS_FS) || (c2 == NEG_FS);
            if (state == ST_IDLE && in_start && !in_abort)
                out_ovr_cnt <= '0;
            else if (s2_vld && (out_ovr_ch1 || out_ovr_ch2) && out_ovr_cnt != '1)
                out_ovr_cnt <= out_ovr_cnt + INT_CNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_adc_dual_capture.sv
// Self-checking bench for adc_dual_capture: directed tables plus randomized traffic against a queue model.
module tb_adc_dual_capture;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        tready;
    logic [13:0] ch1;
    logic [13:0] ch2;
    logic [15:0] cnt;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tlast;
    logic        busy;
    logic        done;
    logic        ovf;
`ifdef ADC_DUAL_CAPTURE_OVR_DET_EN
    logic        ovr1;
    logic        ovr2;
    logic [15:0] ovr_cnt;
`endif

    always #5 clk = ~clk;

    adc_dual_capture #(
        .INT_ADC_DATA_WIDTH      (14),
        .INT_INVERT_IDATA        (0),
        .INT_IDATA_ENC_OFFSETBIN (1),
        .INT_FIFO_DEPTH          (DEPTH),
        .INT_CNT_WIDTH           (16)
    ) dut (
        .in_clk_adc        (clk),
        .in_rst_n          (rst_n),
        .in_adc_data_ch1   (ch1),
        .in_adc_data_ch2   (ch2),
        .in_start          (start),
        .in_abort          (abort),
        .in_sample_count   (cnt),
        .out_m_axis_tdata  (tdata),
        .out_m_axis_tvalid (tvalid),
        .out_m_axis_tlast  (tlast),
        .in_m_axis_tready  (tready),
        .out_busy          (busy),
        .out_done          (done),
        .out_overflow      (ovf)
`ifdef ADC_DUAL_CAPTURE_OVR_DET_EN
       ,.out_ovr_ch1       (ovr1),
        .out_ovr_ch2       (ovr2),
        .out_ovr_cnt       (ovr_cnt)
`endif
    );

    typedef struct {
        logic [31:0] d;
        bit          last;
        int          due;
    } pend_t;

    typedef struct {
        logic [31:0] d;
        bit          last;
    } word_t;

    typedef struct {
        logic [13:0] c1;
        logic [13:0] c2;
        logic [15:0] e1;
        logic [15:0] e2;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    pend_t       pipe[$];
    word_t       mq[$];
    word_t       got[$];
    int          m_st;
    int          m_rem;
    int          cyc;
    bit          park_v;
    logic [31:0] park_d;
    bit          m_ovf;
    bit          m_done;
    bit          seen_v;
    bit          seen_l;
    logic [31:0] seen_d;
    vec_t        vt[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Offset binary: the signed value is the code minus mid-scale.
    function automatic logic [15:0] ref_conv(input logic [13:0] x);
        int v;
        v = int'(x) - 8192;
        return v[15:0];
    endfunction

    function automatic logic [31:0] ref_word(input logic [13:0] a, input logic [13:0] b);
        return {ref_conv(b), ref_conv(a)};
    endfunction

    // Spec-level model: m_st 0=idle 1=capture 2=drain, mq = words the consumer can see.
    task automatic model_update();
        int    qn;
        int    st0;
        bit    pk;
        bit    full;
        bit    ab;
        pend_t it;
        word_t w;
        if (!rst_n) begin
            pipe.delete();
            mq.delete();
            park_v = 0;
            m_st   = 0;
            m_rem  = 0;
            m_ovf  = 0;
            m_done = 0;
        end else begin
            qn     = mq.size();
            pk     = park_v;
            full   = (qn == DEPTH);
            st0    = m_st;
            ab     = abort && (st0 != 0);
            m_done = 0;
            if (ab) begin
                pipe.delete();
                mq.delete();
                park_v = 0;
                m_st   = 0;
                m_rem  = 0;
            end else begin
                if (qn > 0 && tready) mq.delete(0);
                if (pk) begin
                    if (!full) begin
                        w.d = park_d;
                        w.last = 1;
                        mq.push_back(w);
                        park_v = 0;
                    end
                end else if (pipe.size() > 0 && pipe[0].due == cyc) begin
                    it = pipe.pop_front();
                    if (!full) begin
                        w.d = it.d;
                        w.last = it.last;
                        mq.push_back(w);
                    end else if (it.last) begin
                        park_v = 1;
                        park_d = it.d;
                    end else begin
                        m_ovf = 1;
                    end
                    if (it.last) m_st = 2;
                end
                case (st0)
                    0: if (start && !abort) begin
                        if (cnt != 0) begin
                            m_st  = 1;
                            m_rem = int'(cnt);
                            m_ovf = 0;
                        end else begin
                            m_done = 1;
                        end
                    end
                    1: if (m_rem > 0) begin
                        it.d    = ref_word(ch1, ch2);
                        it.last = (m_rem == 1);
                        it.due  = cyc + 2;
                        pipe.push_back(it);
                        m_rem--;
                    end
                    2: if (qn == 0 && !pk) begin
                        m_st   = 0;
                        m_done = 1;
                    end
                    default: ;
                endcase
            end
        end
        cyc++;
    endtask

    task automatic check_cycle();
        seen_v = tvalid;
        seen_d = tdata;
        seen_l = tlast;
        chk("tvalid", tvalid, mq.size() > 0);
        if (mq.size() > 0) begin
            chk("tdata", tdata, mq[0].d);
            chk("tlast", tlast, mq[0].last);
        end
        chk("busy", busy, m_st != 0);
        chk("done", done, m_done);
        chk("overflow", ovf, m_ovf);
    endtask

    task automatic tick();
        @(posedge clk);
        if (seen_v && tready && rst_n) got.push_back('{d: seen_d, last: seen_l});
        model_update();
        @(negedge clk);
        check_cycle();
    endtask

    task automatic wait_done(input int maxc);
        int k;
        k = 0;
        while (!done && k < maxc) begin
            tick();
            k++;
        end
        chk("done_seen", done, 1);
        chk("done_busy_low", busy, 0);
        chk("done_tvalid_low", tvalid, 0);
    endtask

    task automatic run_table(input int n);
        got.delete();
        tready = 1;
        start  = 1;
        cnt    = 16'(n);
        tick();
        start = 0;
        for (int i = 0; i < n; i++) begin
            ch1 = vt[i].c1;
            ch2 = vt[i].c2;
            tick();
        end
        ch1 = 14'h2000;
        ch2 = 14'h2000;
        wait_done(30);
        chk("tbl_len", got.size(), n);
        for (int i = 0; i < n && i < got.size(); i++) begin
            chk("tbl_data", got[i].d, {vt[i].e2, vt[i].e1});
            chk("tbl_last", got[i].last, i == n - 1);
        end
        tick();
    endtask

    initial begin
        int k;
        int nd;
        int exp_lo[5];
        rst_n  = 0;
        start  = 0;
        abort  = 0;
        tready = 1;
        ch1    = 14'h2000;
        ch2    = 14'h2000;
        cnt    = 0;
        cyc    = 0;
        seen_v = 0;

        vt[0] = '{c1: 14'h2000, c2: 14'h2000, e1: 16'h0000, e2: 16'h0000};
        vt[1] = '{c1: 14'h3FFF, c2: 14'h0000, e1: 16'h1FFF, e2: 16'hE000};
        vt[2] = '{c1: 14'h0000, c2: 14'h3FFF, e1: 16'hE000, e2: 16'h1FFF};
        vt[3] = '{c1: 14'h2001, c2: 14'h1FFF, e1: 16'h0001, e2: 16'hFFFF};
        vt[4] = '{c1: 14'h1234, c2: 14'h2ABC, e1: 16'hF234, e2: 16'h0ABC};
        vt[5] = '{c1: 14'h3000, c2: 14'h1000, e1: 16'h1000, e2: 16'hF000};

        @(negedge clk);
        tick();
        tick();
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", ovf, 0);
        rst_n = 1;
        tick();

        // Three-word burst, then the full conversion table.
        run_table(3);
        run_table(6);

        // Stalled consumer: words 5..7 dropped, word 8 parked and delivered with tlast.
        got.delete();
        tready = 0;
        start  = 1;
        cnt    = 8;
        tick();
        start = 0;
        for (int i = 1; i <= 8; i++) begin
            ch1 = 14'(14'h2000 + i);
            ch2 = 14'h2000;
            tick();
        end
        ch1 = 14'h2000;
        repeat (4) tick();
        chk("stall_ovf", ovf, 1);
        tready = 1;
        wait_done(40);
        exp_lo = '{1, 2, 3, 4, 8};
        chk("stall_len", got.size(), 5);
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            chk("stall_data", got[i].d, {16'h0000, 16'(exp_lo[i])});
            chk("stall_last", got[i].last, i == 4);
        end
        chk("stall_ovf_kept", ovf, 1);
        tick();

        // Abort mid-burst, then restart.
        got.delete();
        tready = 1;
        start  = 1;
        cnt    = 100;
        tick();
        start = 0;
        k = 0;
        while (got.size() < 10 && k < 50) begin
            ch1 = 14'($urandom);
            ch2 = 14'($urandom);
            tick();
            k++;
        end
        chk("abort_reached", got.size(), 10);
        abort = 1;
        tick();
        abort = 0;
        chk("abort_tvalid", tvalid, 0);
        chk("abort_busy", busy, 0);
        nd = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done) nd++;
        end
        chk("abort_no_done", nd, 0);
        start = 1;
        cnt   = 2;
        tick();
        start = 0;
        chk("restart_busy", busy, 1);
        wait_done(20);
        tick();

        // Zero-length request, ignored start while busy, start+abort in idle.
        got.delete();
        start = 1;
        cnt   = 0;
        tick();
        start = 0;
        chk("zero_done", done, 1);
        chk("zero_tvalid", tvalid, 0);
        chk("zero_busy", busy, 0);
        tick();
        chk("zero_done_pulse", done, 0);
        chk("zero_no_words", got.size(), 0);
        start = 1;
        cnt   = 5;
        tick();
        start = 0;
        tick();
        start = 1;
        cnt   = 50;
        tick();
        start = 0;
        wait_done(40);
        chk("busy_ignore_len", got.size(), 5);
        tick();
        start = 1;
        abort = 1;
        cnt   = 4;
        tick();
        start = 0;
        abort = 0;
        chk("start_abort_busy", busy, 0);

        // Reset in the middle of a capture.
        start = 1;
        cnt   = 20;
        tick();
        start = 0;
        repeat (8) tick();
        rst_n = 0;
        tick();
        chk("mid_rst_tvalid", tvalid, 0);
        chk("mid_rst_tdata", tdata, 0);
        chk("mid_rst_tlast", tlast, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_ovf", ovf, 0);
        rst_n = 1;
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done || tvalid) nd++;
        end
        chk("mid_rst_quiet", nd, 0);

`ifdef ADC_DUAL_CAPTURE_OVR_DET_EN
        ch1 = 14'h2000;
        ch2 = 14'h2000;
        tick();
        tick();
        start = 1;
        cnt   = 4;
        tick();
        start = 0;
        nd = 0;
        for (int i = 0; i < 4; i++) begin
            ch1 = (i < 2) ? 14'h3FFF : 14'h2100;
            tick();
            if (ovr1) nd++;
        end
        ch1 = 14'h2000;
        k = 0;
        while (!done && k < 20) begin
            tick();
            if (ovr1) nd++;
            k++;
        end
        chk("ovr_pulses", nd, 2);
        chk("ovr_cnt", ovr_cnt, 2);
        tick();
`endif

        // Randomized traffic checked cycle by cycle against the model.
        for (int i = 0; i < 2500; i++) begin
            ch1    = 14'($urandom);
            ch2    = 14'($urandom);
            tready = ($urandom_range(0, 3) != 0);
            start  = ($urandom_range(0, 9) == 0);
            cnt    = 16'($urandom_range(0, 12));
            abort  = ($urandom_range(0, 79) == 0);
            tick();
        end
        start  = 0;
        abort  = 0;
        tready = 1;
        k = 0;
        while (busy && k < 60) begin
            tick();
            k++;
        end
        chk("final_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
